mc_ctrl_fsm: RTL
================

Name: mc_ctrl_fsm

Overview:
Parametrised multi-cycle control unit for the ARM-subset datapath. It sequences fetch, decode, execute, memory and writeback from one-hot decoded command lines. Memory accesses use a mem_req/mem_ready handshake with a configurable timeout. The block adds optional IRQ entry at instruction boundaries and a sticky fault state.

Parameters:
CMD_W, 9, width of the one-hot command vector (bit0 DP, 1 BX, 2 B, 3 BL, 4 LDR0, 5 LDR1, 6 STR0, 7 STR1, 8 SWP; higher bits treated as DP)
TIMEOUT, 16, max wait cycles for mem_ready before fault; 0 disables the timeout
IRQ_EN, 1, 1 enables interrupt entry; 0 ties irq off internally

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cmd  in  CMD_W  one-hot decoded instruction, valid from DECODE onward
alu_op  in  4  decoded ALU opcode for DP instructions
cond_pass  in  1  condition check result, sampled in EXEC
s_in  in  1  instruction S bit
p  in  1  pre(1)/post(0) index
u  in  1  add(1)/subtract(0) offset
w  in  1  base writeback request
irq  in  1  level interrupt request
mem_ready  in  1  memory completes the current mem_req this cycle
write_pc  out  1  PC load enable
write_ir  out  1  IR load enable
write_reg  out  1  register file write enable
ld_abc  out  1  load A/B/C operand latches
lf  out  1  load F result latch
pc_s  out  2  PC source: 00 PC+4, 01 B, 10 F, 11 IRQ vector
alu_a_s  out  1  ALU A source: 0 A, 1 PC
alu_b_s  out  2  ALU B source: 00 B, 01 ext(imm24), 10 imm12
rd_s  out  2  write address: 00 rd, 01 R14, 10 rn
w_rdata_s  out  2  write data: 00 F, 10 memory read data
mem_req  out  1  memory request, held until mem_ready
mem_write  out  1  write qualifier for mem_req
alu_op_ctrl  out  4  ALU opcode: 0100 add, 0010 sub, 1000 pass A
s_ctrl  out  1  flag update enable, EXEC of DP only
fault  out  1  sticky memory timeout flag

Behaviour:
- Moore outputs, decoded from the registered state only. While rst_n=0 all outputs are 0 and the state is IDLE; any state is aborted immediately, including a pending mem_req.
- IDLE -> FETCH unconditionally.
- FETCH: mem_req=1, write_ir=1 qualified by mem_ready. On mem_ready, write_pc=1 with pc_s=00, then go to DECODE. If irq is sampled in FETCH's first cycle with IRQ_EN=1, go to IRQ_SAVE without issuing the fetch.
- DECODE: ld_abc=1. Next state: B -> BR_CALC; BL -> BL_LINK; BX -> BX_ST; LDR/STR -> ADDR; SWP -> SWP_RD; otherwise EXEC.
- EXEC: lf=1, alu_op_ctrl=alu_op, s_ctrl=s_in & cond_pass. If cond_pass -> WB, else -> FETCH. WB: write_reg=1, rd_s=00, w_rdata_s=00 -> FETCH.
- BX_ST: write_pc=1, pc_s=01 -> FETCH.
- BL_LINK: alu_a_s=1, op 1000, lf=1 -> BL_WR. BL_WR: write_reg=1, rd_s=01; also alu_a_s=1, alu_b_s=01, op 0100, lf=1 -> BR_WB.
- BR_CALC: same ALU setup as BL_WR without the register write -> BR_WB. BR_WB: write_pc=1, pc_s=10 -> FETCH.
- ADDR: lf=1, alu_b_s=10. If p=1, op is 0100 when u=1 and 0010 when u=0; if p=0, op is 1000. Loads -> LD_MEM; stores -> ST_MEM.
- LD_MEM: mem_req=1, mem_write=0; on mem_ready -> LD_WB. LD_WB: write_reg=1, rd_s=00, w_rdata_s=10. Then, if w=1 or p=0, compute base+/-offset into F -> BASE_WB; else -> FETCH.
- ST_MEM: mem_req=1, mem_write=1; on mem_ready it follows the same base rule as LD_WB.
- BASE_WB: write_reg=1, rd_s=10, w_rdata_s=00 -> FETCH.
- SWP_RD: load via LD_MEM-style wait into rd. SWP_WR: store B via ST_MEM-style wait -> FETCH. No base writeback for SWP.
- Timeout: the wait counter clears on entry to every mem state. If the counter reaches TIMEOUT with no mem_ready (TIMEOUT>0) -> FAULT. FAULT: fault=1, all enables 0; it is left only by reset. mem_ready in the cycle the count equals TIMEOUT wins over the timeout.
- IRQ_SAVE: alu_a_s=1, op 1000, lf=1 -> IRQ_LINK. IRQ_LINK: write_reg=1, rd_s=01, w_rdata_s=00; write_pc=1, pc_s=11 -> FETCH. irq is ignored in every other state.
- A zero or multi-hot cmd uses a priority order: B > BL > BX > LDR/STR > SWP > DP.

Test Plan:
- Reset mid-LD_MEM with mem_req=1 -> mem_req=0 asynchronously; after release, IDLE then FETCH on the next edge.
- DP add, cond_pass=1, mem_ready on the first FETCH cycle -> FETCH, DECODE, EXEC, WB (4 cycles); write_reg=1 only in WB.
- DP with cond_pass=0 -> EXEC then FETCH; write_reg never asserted and s_ctrl=0.
- LDR0 p=0 u=1 w=0 with mem_ready after 3 cycles -> mem_req high for exactly 3 cycles, LD_WB write_reg with w_rdata_s=10, then BASE_WB with rd_s=10.
- TIMEOUT=4 with mem_ready never asserted in ST_MEM -> FAULT after 4 wait cycles; fault stays 1 until rst_n=0.
- irq=1 at FETCH entry with IRQ_EN=1 -> IRQ_SAVE, then IRQ_LINK with write_reg=1, rd_s=01, write_pc=1, pc_s=11; no mem_req issued before the vector load.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/writeback with
// mem_req/mem_ready handshake, wait timeout into a sticky fault, and IRQ entry.
// Outputs are decoded from the state register. The exceptions are the FETCH
// strobes, which are qualified by mem_ready (write_ir/write_pc) or by irq in
// the first FETCH cycle (mem_req).
// Store base writeback goes through ST_BASE, which computes base +/- offset
// without disturbing F while the store is pending. Swap returns the read data
// to rd in SWP_WB before the store phase.
module mc_ctrl_fsm #(
  parameter int unsigned CMD_W   = 9,
  parameter int unsigned TIMEOUT = 16,
  parameter bit          IRQ_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CMD_W-1:0] cmd,
  input  logic [3:0]       alu_op,
  input  logic             cond_pass,
  input  logic             s_in,
  input  logic             p,
  input  logic             u,
  input  logic             w,
  input  logic             irq,
  input  logic             mem_ready,
  output logic             write_pc,
  output logic             write_ir,
  output logic             write_reg,
  output logic             ld_abc,
  output logic             lf,
  output logic [1:0]       pc_s,
  output logic             alu_a_s,
  output logic [1:0]       alu_b_s,
  output logic [1:0]       rd_s,
  output logic [1:0]       w_rdata_s,
  output logic             mem_req,
  output logic             mem_write,
  output logic [3:0]       alu_op_ctrl,
  output logic             s_ctrl,
  output logic             fault
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_PASS = 4'b1000;

  typedef enum logic [4:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_BX_ST, S_BL_LINK, S_BL_WR,
    S_BR_CALC, S_BR_WB, S_ADDR, S_LD_MEM, S_LD_WB, S_ST_MEM, S_ST_BASE,
    S_BASE_WB, S_SWP_RD, S_SWP_WB, S_SWP_WR, S_IRQ_SAVE, S_IRQ_LINK, S_FAULT
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [8:0]       c9;
  logic             irq_eff, fetch_first, timed_out, base_wb;
  logic [3:0]       addr_op, off_op;

  assign c9          = 9'(cmd);
  assign irq_eff     = IRQ_EN ? irq : 1'b0;
  assign fetch_first = (cnt == '0);
  assign timed_out   = (TIMEOUT != 0) && !mem_ready && (cnt == CNT_LAST);
  assign base_wb     = w | ~p;
  assign off_op      = u ? OP_ADD : OP_SUB;
  assign addr_op     = p ? off_op : OP_PASS;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Wait counter: cleared on every state change, saturating while a state holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (next_state != state)  cnt <= '0;
    else if (cnt != CNT_MAX)       cnt <= cnt + CNT_W'(1);
  end

  // Next-state and output decode
  always_comb begin
    next_state  = state;
    write_pc    = 1'b0;
    write_ir    = 1'b0;
    write_reg   = 1'b0;
    ld_abc      = 1'b0;
    lf          = 1'b0;
    pc_s        = 2'b00;
    alu_a_s     = 1'b0;
    alu_b_s     = 2'b00;
    rd_s        = 2'b00;
    w_rdata_s   = 2'b00;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    alu_op_ctrl = 4'b0000;
    s_ctrl      = 1'b0;
    fault       = 1'b0;
    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        if (irq_eff && fetch_first) begin
          next_state = S_IRQ_SAVE;
        end else begin
          mem_req  = 1'b1;
          write_ir = mem_ready;
          write_pc = mem_ready;
          if (mem_ready)      next_state = S_DECODE;
          else if (timed_out) next_state = S_FAULT;
        end
      end
      S_DECODE: begin
        ld_abc = 1'b1;
        if (c9[2])                             next_state = S_BR_CALC;
        else if (c9[3])                        next_state = S_BL_LINK;
        else if (c9[1])                        next_state = S_BX_ST;
        else if (c9[4] | c9[5] | c9[6] | c9[7]) next_state = S_ADDR;
        else if (c9[8])                        next_state = S_SWP_RD;
        else                                   next_state = S_EXEC;
      end
      S_EXEC: begin
        lf          = 1'b1;
        alu_op_ctrl = alu_op;
        s_ctrl      = s_in & cond_pass;
        next_state  = cond_pass ? S_WB : S_FETCH;
      end
      S_WB: begin
        write_reg  = 1'b1;
        next_state = S_FETCH;
      end
      S_BX_ST: begin
        write_pc   = 1'b1;
        pc_s       = 2'b01;
        next_state = S_FETCH;
      end
      S_BL_LINK: begin
        alu_a_s     = 1'b1;
        alu_op_ctrl = OP_PASS;
        lf          = 1'b1;
        next_state  = S_BL_WR;
      end
      S_BL_WR, S_BR_CALC: begin
        write_reg   = (state == S_BL_WR);
        rd_s        = (state == S_BL_WR) ? 2'b01 : 2'b00;
        alu_a_s     = 1'b1;
        alu_b_s     = 2'b01;
        alu_op_ctrl = OP_ADD;
        lf          = 1'b1;
        next_state  = S_BR_WB;
      end
      S_BR_WB: begin
        write_pc   = 1'b1;
        pc_s       = 2'b10;
        next_state = S_FETCH;
      end
      S_ADDR: begin
        lf          = 1'b1;
        alu_b_s     = 2'b10;
        alu_op_ctrl = addr_op;
        next_state  = (c9[4] | c9[5]) ? S_LD_MEM : S_ST_MEM;
      end
      S_LD_MEM, S_SWP_RD: begin
        mem_req = 1'b1;
        if (mem_ready)      next_state = (state == S_LD_MEM) ? S_LD_WB : S_SWP_WB;
        else if (timed_out) next_state = S_FAULT;
      end
      S_LD_WB: begin
        write_reg  = 1'b1;
        w_rdata_s  = 2'b10;
        next_state = S_FETCH;
        if (base_wb) begin
          lf          = 1'b1;
          alu_b_s     = 2'b10;
          alu_op_ctrl = off_op;
          next_state  = S_BASE_WB;
        end
      end
      S_ST_MEM: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready)      next_state = base_wb ? S_ST_BASE : S_FETCH;
        else if (timed_out) next_state = S_FAULT;
      end
      S_ST_BASE: begin
        lf          = 1'b1;
        alu_b_s     = 2'b10;
        alu_op_ctrl = off_op;
        next_state  = S_BASE_WB;
      end
      S_BASE_WB: begin
        write_reg  = 1'b1;
        rd_s       = 2'b10;
        next_state = S_FETCH;
      end
      S_SWP_WB: begin
        write_reg  = 1'b1;
        w_rdata_s  = 2'b10;
        next_state = S_SWP_WR;
      end
      S_SWP_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready)      next_state = S_FETCH;
        else if (timed_out) next_state = S_FAULT;
      end
      S_IRQ_SAVE: begin
        alu_a_s     = 1'b1;
        alu_op_ctrl = OP_PASS;
        lf          = 1'b1;
        next_state  = S_IRQ_LINK;
      end
      S_IRQ_LINK: begin
        write_reg  = 1'b1;
        rd_s       = 2'b01;
        write_pc   = 1'b1;
        pc_s       = 2'b11;
        next_state = S_FETCH;
      end
      S_FAULT: fault = 1'b1;
      default: next_state = S_IDLE;
    endcase
  end

endmodule
